// File: rtl/shift_unit_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL) with valid/ready flow control.
// Optional registers between log2 shift levels; the output register is always present.
module shift_unit_pipe #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned STAGE_REG = 5'b01010,
    parameter int unsigned TAG_W     = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [$clog2(WIDTH)-1:0]   in_shamt,
    input  logic [1:0]                 in_op,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [TAG_W-1:0]           out_tag,
    output logic                       out_zero
);

    localparam int unsigned SHAMT_W = $clog2(WIDTH);
    localparam logic [SHAMT_W-1:0] REGMASK = SHAMT_W'(STAGE_REG);

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROL = 2'b11
    } op_e;

    typedef struct packed {
        logic               v;
        logic [WIDTH-1:0]   d;
        logic [SHAMT_W-1:0] sh;
        op_e                op;
        logic               sg;
        logic [TAG_W-1:0]   tag;
    } stage_t;

    function automatic stage_t shift_level(stage_t s, int unsigned lvl);
        stage_t          r;
        logic [WIDTH:0]  ext;
        int unsigned     amt;
        r   = s;
        amt = 2 ** lvl;
        ext = {s.sg, s.d};
        if (s.sh[lvl]) begin
            case (s.op)
                OP_SLL:  r.d = s.d << amt;
                OP_SRL:  r.d = s.d >> amt;
                OP_SRA:  r.d = WIDTH'($signed(ext) >>> amt);
                default: r.d = (s.d << amt) | (s.d >> (WIDTH - amt));
            endcase
        end
        return r;
    endfunction

    logic   rdy_en;
    stage_t stage_r [SHAMT_W];
    stage_t lvl_out [SHAMT_W];
    logic   ld      [SHAMT_W];
    logic   out_ld;
    logic               fin_v;
    logic [WIDTH-1:0]   fin_d;
    logic [TAG_W-1:0]   fin_tag;

    // Forward pass walks the levels, substituting the registered copy wherever a stage
    // register sits; backward pass builds the ready chain from the output register.
    always_comb begin
        stage_t cur;
        logic   rdy;
        cur.v   = in_valid & rdy_en;
        cur.d   = cur.v ? in_data : '0;
        cur.sh  = cur.v ? in_shamt : '0;
        cur.op  = op_e'(cur.v ? in_op : 2'b00);
        cur.sg  = cur.v & in_data[WIDTH-1];
        cur.tag = cur.v ? in_tag : '0;
        for (int unsigned i = 0; i < SHAMT_W; i++) begin
            cur        = shift_level(cur, i);
            lvl_out[i] = cur;
            if (REGMASK[i]) begin
                cur = stage_r[i];
            end
        end
        fin_v   = cur.v;
        fin_d   = cur.d;
        fin_tag = cur.tag;

        out_ld = ~out_valid | out_ready;
        rdy    = out_ld;
        for (int unsigned k = 0; k < SHAMT_W; k++) begin
            ld[SHAMT_W-1-k] = ~stage_r[SHAMT_W-1-k].v | rdy;
            if (REGMASK[SHAMT_W-1-k]) begin
                rdy = ld[SHAMT_W-1-k];
            end
        end
        in_ready = rdy_en & rdy;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdy_en    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
            out_zero  <= 1'b0;
            for (int unsigned i = 0; i < SHAMT_W; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            rdy_en <= 1'b1;
            for (int unsigned i = 0; i < SHAMT_W; i++) begin
                if (REGMASK[i] && ld[i]) begin
                    stage_r[i] <= lvl_out[i];
                end
            end
            if (out_ld) begin
                out_valid <= fin_v;
                out_data  <= fin_d;
                out_tag   <= fin_tag;
                out_zero  <= fin_v & (fin_d == '0);
            end
        end
    end

endmodule
